// File: rtl/uart_rx_fifo_io_pkg.sv
// Shared IO-page constants and bus word layouts for the UART receive buffer.
// The soc decode uses the same address bits and status/control positions.
package uart_rx_fifo_io_pkg;

   localparam int unsigned FIFO_DEPTH_LOG2  = 4;
   localparam int unsigned DATA_W           = 8;
   localparam int unsigned BUS_W            = 32;
   localparam int unsigned ADDR_W           = 30;

   // Word-address bits of the IO page
   localparam int unsigned ADDR_LEDS_BIT    = 0;
   localparam int unsigned ADDR_TX_DATA_BIT = 1;
   localparam int unsigned ADDR_RX_DATA_BIT = 2;
   localparam int unsigned ADDR_CTRL_BIT    = 3;

   // Status word bit positions
   localparam int unsigned ST_TX_READY      = 0;
   localparam int unsigned ST_RX_AVAIL      = 1;
   localparam int unsigned ST_OVF           = 2;
   localparam int unsigned ST_COUNT_LSB     = 8;

   // Control word bit positions
   localparam int unsigned CT_CLR_OVF       = 2;
   localparam int unsigned CT_FLUSH         = 3;

   // Status word as returned on a control-register read
   typedef struct packed {
      logic [15:0] rsvd_hi;
      logic [7:0]  count;
      logic [4:0]  rsvd_lo;
      logic        ovf;
      logic        rx_avail;
      logic        tx_ready;
   } status_word_t;

   // Data word as returned on an RX-data read; valid distinguishes 0x00 from empty
   typedef struct packed {
      logic [22:0] rsvd;
      logic        valid;
      logic [7:0]  data;
   } rx_word_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush; pointers and occupancy count live here.
// A pop frees a slot in the same cycle, so push+pop on a full FIFO is accepted.
module sync_fifo #(
   parameter int unsigned DEPTH_LOG2 = 4,
   parameter int unsigned WIDTH      = 8
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  push,
   input  logic                  pop,
   input  logic                  flush,
   input  logic [WIDTH-1:0]      din,
   output logic [WIDTH-1:0]      dout,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  full,
   output logic                  empty
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

   logic [WIDTH-1:0]      mem [DEPTH];
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic                  do_pop;
   logic                  do_push;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign dout    = mem[rd_ptr];

   // Flush dominates both directions; an empty pop is a no-op
   assign do_pop  = pop  & ~empty & ~flush;
   assign do_push = push & (~full | do_pop) & ~flush;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= wr_ptr;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
         if (do_pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   // Storage is deliberately not reset
   always_ff @(posedge clk) begin
      if (do_push && resetn) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/uart_rx_fifo_io.sv
// Memory-mapped UART receive buffer: captures rx bytes into a FIFO and serves
// pop-on-read data and status/control words with RAM-like one-cycle read latency.
module uart_rx_fifo_io
   import uart_rx_fifo_io_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2  = FIFO_DEPTH_LOG2,
   parameter int unsigned RX_DATA_BIT = ADDR_RX_DATA_BIT,
   parameter int unsigned CTRL_BIT    = ADDR_CTRL_BIT
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              rx_dv,
   input  logic [7:0]        rx_byte,
   input  logic              tx_active,
   input  logic              io_sel,
   input  logic [29:0]       io_wordaddr,
   input  logic              io_rstrb,
   input  logic              io_wstrb,
   input  logic [31:0]       io_wdata,
   output logic [31:0]       io_rdata,
   output logic              rx_nonempty
);

   logic                  rd_sel;
   logic                  ctrl_sel;
   logic                  pop;
   logic                  ctrl_wr;
   logic                  flush;
   logic                  clr_ovf;
   logic                  ovf_set;
   logic                  overflow;
   logic [DATA_W-1:0]     fifo_dout;
   logic [DEPTH_LOG2:0]   fifo_count;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [BUS_W-1:0]      rdata_nxt;
   status_word_t          status_w;
   rx_word_t              rx_w;
   logic                  unused_bits;

   // RX data wins when both address bits are set
   assign rd_sel   = io_sel & io_wordaddr[RX_DATA_BIT];
   assign ctrl_sel = io_sel & io_wordaddr[CTRL_BIT] & ~io_wordaddr[RX_DATA_BIT];

   assign pop      = io_rstrb & rd_sel;
   assign ctrl_wr  = io_wstrb & ctrl_sel;
   assign flush    = ctrl_wr & io_wdata[CT_FLUSH];
   assign clr_ovf  = ctrl_wr & io_wdata[CT_CLR_OVF];

   // A same-cycle pop makes room, and a flush discards the byte silently
   assign ovf_set  = rx_dv & fifo_full & ~pop & ~flush;

   assign rx_nonempty = (fifo_count != '0);

   sync_fifo #(
      .DEPTH_LOG2 (DEPTH_LOG2),
      .WIDTH      (DATA_W)
   ) u_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (rx_dv),
      .pop    (pop),
      .flush  (flush),
      .din    (rx_byte),
      .dout   (fifo_dout),
      .count  (fifo_count),
      .full   (fifo_full),
      .empty  (fifo_empty)
   );

   // Sticky overflow; a new overflow beats a same-cycle clear
   always_ff @(posedge clk) begin
      if (!resetn)      overflow <= 1'b0;
      else if (ovf_set) overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
   end

   always_comb begin
      status_w          = '0;
      status_w.count    = 8'(fifo_count);
      status_w.ovf      = overflow;
      status_w.rx_avail = rx_nonempty;
      status_w.tx_ready = ~tx_active;

      rx_w       = '0;
      rx_w.valid = 1'b1;
      rx_w.data  = fifo_dout;
   end

   // Read mux: hold without a strobe, zero for an unmapped or empty read
   always_comb begin
      rdata_nxt = io_rdata;
      if (io_rstrb) begin
         if (rd_sel)        rdata_nxt = fifo_empty ? '0 : BUS_W'(rx_w);
         else if (ctrl_sel) rdata_nxt = BUS_W'(status_w);
         else               rdata_nxt = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) io_rdata <= '0;
      else         io_rdata <= rdata_nxt;
   end

   assign unused_bits = &{1'b0, io_wordaddr, io_wdata};

endmodule

// File: tb/tb_uart_rx_fifo_io.sv
// Directed bench for uart_rx_fifo_io: FIFO ordering, overflow, flush,
// simultaneous-event priorities, reset and pointer wrap.
module tb_uart_rx_fifo_io;

   logic        clk;
   logic        resetn;
   logic        rx_dv;
   logic [7:0]  rx_byte;
   logic        tx_active;
   logic        io_sel;
   logic [29:0] io_wordaddr;
   logic        io_rstrb;
   logic        io_wstrb;
   logic [31:0] io_wdata;
   logic [31:0] io_rdata;
   logic        rx_nonempty;

   int errors = 0;
   int checks = 0;

   localparam logic [29:0] A_RX   = 30'h4;
   localparam logic [29:0] A_CTRL = 30'h8;
   localparam logic [29:0] A_NONE = 30'h0;

   uart_rx_fifo_io dut (
      .clk         (clk),
      .resetn      (resetn),
      .rx_dv       (rx_dv),
      .rx_byte     (rx_byte),
      .tx_active   (tx_active),
      .io_sel      (io_sel),
      .io_wordaddr (io_wordaddr),
      .io_rstrb    (io_rstrb),
      .io_wstrb    (io_wstrb),
      .io_wdata    (io_wdata),
      .io_rdata    (io_rdata),
      .rx_nonempty (rx_nonempty)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One bus/rx cycle with any combination of events
   task automatic cyc(input logic dv, input logic [7:0] b, input logic sel,
                      input logic rs, input logic ws, input logic [29:0] a,
                      input logic [31:0] wd);
      rx_dv = dv; rx_byte = b; io_sel = sel; io_rstrb = rs; io_wstrb = ws;
      io_wordaddr = a; io_wdata = wd;
      step();
      rx_dv = 1'b0; io_sel = 1'b0; io_rstrb = 1'b0; io_wstrb = 1'b0;
      io_wordaddr = '0; io_wdata = '0;
   endtask

   task automatic push(input logic [7:0] b);
      cyc(1'b1, b, 1'b0, 1'b0, 1'b0, A_NONE, 32'h0);
   endtask

   task automatic rd_data(input string tag, input logic [31:0] exp);
      cyc(1'b0, 8'h0, 1'b1, 1'b1, 1'b0, A_RX, 32'h0);
      chk(tag, io_rdata, exp);
   endtask

   task automatic rd_stat(input string tag, input logic [31:0] exp);
      cyc(1'b0, 8'h0, 1'b1, 1'b1, 1'b0, A_CTRL, 32'h0);
      chk(tag, io_rdata, exp);
   endtask

   task automatic wr_ctrl(input logic [31:0] v);
      cyc(1'b0, 8'h0, 1'b1, 1'b0, 1'b1, A_CTRL, v);
   endtask

   initial begin
      resetn = 1'b0; rx_dv = 1'b0; rx_byte = '0; tx_active = 1'b0;
      io_sel = 1'b0; io_wordaddr = '0; io_rstrb = 1'b0; io_wstrb = 1'b0; io_wdata = '0;
      step(); step();
      resetn = 1'b1;

      // Reset state
      chk("reset_rdata", io_rdata, 32'h0);
      chk("reset_nonempty", {31'b0, rx_nonempty}, 32'h0);
      rd_stat("reset_status", 32'h0000_0001);
      rd_data("reset_data_empty", 32'h0000_0000);

      // Basic ordering
      push(8'h41); push(8'h42); push(8'h43);
      chk("three_nonempty", {31'b0, rx_nonempty}, 32'h1);
      rd_stat("three_status", 32'h0000_0303);
      rd_data("three_rd0", 32'h141);
      step(); step(); step();
      chk("rdata_hold", io_rdata, 32'h141);
      rd_data("three_rd1", 32'h142);
      rd_data("three_rd2", 32'h143);
      rd_data("three_rd3_empty", 32'h0);

      // Overflow: 17 pushes, last byte dropped
      for (int i = 0; i <= 16; i++) push(8'(i));
      rd_stat("ovf_status", 32'h0000_1007);
      for (int i = 0; i < 16; i++) rd_data("ovf_drain", 32'h100 + 32'(i));
      chk("ovf_drained_nonempty", {31'b0, rx_nonempty}, 32'h0);
      rd_data("ovf_lost_byte", 32'h0);
      wr_ctrl(32'h4);
      rd_stat("ovf_cleared", 32'h0000_0001);

      // Push + pop while full: push accepted, no overflow
      for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
      cyc(1'b1, 8'h55, 1'b1, 1'b1, 1'b0, A_RX, 32'h0);
      chk("full_pushpop_rd", io_rdata, 32'h120);
      rd_stat("full_pushpop_status", 32'h0000_1003);
      for (int i = 1; i < 16; i++) rd_data("full_pushpop_drain", 32'h120 + 32'(i));
      rd_data("full_pushpop_last", 32'h155);
      rd_stat("full_pushpop_empty", 32'h0000_0001);

      // Flush beats simultaneous push
      for (int i = 0; i < 5; i++) push(8'h90 + 8'(i));
      cyc(1'b1, 8'h99, 1'b1, 1'b0, 1'b1, A_CTRL, 32'h8);
      chk("flush_nonempty", {31'b0, rx_nonempty}, 32'h0);
      rd_stat("flush_status", 32'h0000_0001);
      rd_data("flush_data", 32'h0);

      // Push + pop while empty: empty response, byte kept
      cyc(1'b1, 8'h77, 1'b1, 1'b1, 1'b0, A_RX, 32'h0);
      chk("empty_pushpop_rd", io_rdata, 32'h0);
      rd_stat("empty_pushpop_status", 32'h0000_0103);
      rd_data("empty_pushpop_data", 32'h177);

      // Writes to the data register are ignored
      push(8'h33);
      cyc(1'b0, 8'h0, 1'b1, 1'b0, 1'b1, A_RX, 32'hC);
      rd_stat("wr_rx_ignored", 32'h0000_0103);
      rd_data("wr_rx_data", 32'h133);

      // Unselected reads return zero and do not pop
      push(8'h44);
      cyc(1'b0, 8'h0, 1'b1, 1'b1, 1'b0, A_NONE, 32'h0);
      chk("nosel_rd", io_rdata, 32'h0);
      rd_data("nosel_pre", 32'h144);
      push(8'h45);
      cyc(1'b0, 8'h0, 1'b0, 1'b1, 1'b0, A_RX, 32'h0);
      chk("iosel_low_rd", io_rdata, 32'h0);
      tx_active = 1'b1;
      rd_stat("tx_busy_status", 32'h0000_0102);
      tx_active = 1'b0;
      rd_data("iosel_low_kept", 32'h145);

      // Both address bits set: RX data wins
      push(8'h46);
      cyc(1'b0, 8'h0, 1'b1, 1'b1, 1'b0, 30'hC, 32'h0);
      chk("both_bits_rx", io_rdata, 32'h146);

      // Clear + new overflow: set wins
      for (int i = 0; i < 16; i++) push(8'h50 + 8'(i));
      push(8'hEE);
      rd_stat("ovf2_status", 32'h0000_1007);
      cyc(1'b1, 8'hEF, 1'b1, 1'b0, 1'b1, A_CTRL, 32'h4);
      rd_stat("clr_vs_set", 32'h0000_1007);
      wr_ctrl(32'h8);
      rd_stat("flush_keeps_ovf", 32'h0000_0005);
      wr_ctrl(32'h4);
      rd_stat("ovf2_cleared", 32'h0000_0001);

      // Reset mid-stream discards buffered bytes
      push(8'hA0); push(8'hA1); push(8'hA2);
      rd_data("prereset_rd", 32'h1A0);
      resetn = 1'b0;
      step();
      resetn = 1'b1;
      chk("midreset_rdata", io_rdata, 32'h0);
      chk("midreset_nonempty", {31'b0, rx_nonempty}, 32'h0);
      rd_stat("midreset_status", 32'h0000_0001);
      rd_data("midreset_data", 32'h0);

      // Pointer wrap
      for (int i = 0; i < 20; i++) begin
         push(8'h60 + 8'(i));
         rd_data("wrap_pair", 32'h160 + 32'(i));
      end
      push(8'hA5);
      rd_data("wrap_final", 32'h1A5);
      rd_stat("wrap_status", 32'h0000_0001);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
